// File: rtl/clock_pkg.sv
// Shared encodings for the clock/alarm time-setting logic.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    COUNT = 2'd2
  } state_t;

  typedef enum logic {
    MIN  = 1'b0,
    HOUR = 1'b1
  } kind_t;

endpackage

// File: rtl/hold_repeat_timer.sv
// Loadable, tick-enabled down-counter that flags the tick on which the
// count reaches its final step.
module hold_repeat_timer #(
  parameter int CW = 3
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic          expire
);

  logic [CW-1:0] r_cnt;

  // Stops at 1 instead of wrapping; the owner reloads on expiry.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick && (r_cnt > CW'(1))) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign expire = tick && (r_cnt == CW'(1));

endmodule

// File: rtl/set_repeat_control.sv
// Manual minute/hour setting for CH channels with hold-to-repeat, plus
// carry pass-through on channel 0 that never loses an increment.
module set_repeat_control
  import clock_pkg::*;
#(
  parameter int CH           = 3,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  localparam int SELW        = (CH > 2) ? $clog2(CH) : 1
) (
  input  logic            ck,
  input  logic            reset,
  input  logic            tick,
  input  logic            btn_min,
  input  logic            btn_hour,
  input  logic [SELW-1:0] sel,
  input  logic            min_carry,
  input  logic            hour_carry,
  output logic [CH-1:0]   up_min,
  output logic [CH-1:0]   up_hour,
  output logic            busy
);

  localparam int MAXT = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  kind_t           r_kind;
  logic [SELW-1:0] r_ch;
  logic            r_first;
  logic            r_pend_min;
  logic            r_pend_hour;

  logic            w_btn;
  logic            w_sel_ok;
  logic            w_expire;
  logic            w_tick_cnt;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic [CH-1:0]   w_man_min;
  logic [CH-1:0]   w_man_hour;

  assign w_sel_ok   = (int'(sel) < CH);
  assign w_btn      = (r_kind == MIN) ? btn_min : btn_hour;
  assign w_tick_cnt = tick && (r_state == COUNT);
  assign w_load_val = r_first ? CW'(HOLD_TICKS) : CW'(REPEAT_TICKS);

  hold_repeat_timer #(
    .CW(CW)
  ) u_timer (
    .ck       (ck),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (w_tick_cnt),
    .expire   (w_expire)
  );

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_man_min   = '0;
    w_man_hour  = '0;
    case (r_state)
      IDLE: begin
        if ((btn_min || btn_hour) && w_sel_ok) begin
          w_state_nxt = PULSE;
        end
      end
      PULSE: begin
        w_load = 1'b1;
        for (int i = 0; i < CH; i++) begin
          if (r_ch == SELW'(i)) begin
            if (r_kind == MIN) begin
              w_man_min[i] = 1'b1;
            end else begin
              w_man_hour[i] = 1'b1;
            end
          end
        end
        w_state_nxt = w_btn ? COUNT : IDLE;
      end
      COUNT: begin
        // Release wins over an expiry landing in the same cycle.
        if (!w_btn) begin
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_state_nxt = PULSE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Kind and channel are frozen for the whole press; min wins a tie.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_kind  <= MIN;
      r_ch    <= '0;
      r_first <= 1'b0;
    end else if ((r_state == IDLE) && (w_state_nxt == PULSE)) begin
      r_kind  <= btn_min ? MIN : HOUR;
      r_ch    <= sel;
      r_first <= 1'b1;
    end else if (r_state == PULSE) begin
      r_first <= 1'b0;
    end
  end

  // A manual pulse colliding with a carry is deferred to the first carry-free cycle.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_pend_min  <= 1'b0;
      r_pend_hour <= 1'b0;
    end else begin
      r_pend_min  <= (w_man_min[0]  || r_pend_min)  && min_carry;
      r_pend_hour <= (w_man_hour[0] || r_pend_hour) && hour_carry;
    end
  end

  always_comb begin
    up_min     = w_man_min;
    up_hour    = w_man_hour;
    up_min[0]  = min_carry  | w_man_min[0]  | r_pend_min;
    up_hour[0] = hour_carry | w_man_hour[0] | r_pend_hour;
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_set_repeat_control.sv
// Randomized self-checking bench for set_repeat_control; expected pulse times
// come from an arithmetic model of press/hold/repeat timing over the tick schedule.
module tb_set_repeat_control;

  localparam int CH   = 3;
  localparam int HOLD = 4;
  localparam int REP  = 2;

  logic          ck = 1'b0;
  logic          reset;
  logic          tick;
  logic          btn_min;
  logic          btn_hour;
  logic [1:0]    sel;
  logic          min_carry;
  logic          hour_carry;
  logic [CH-1:0] up_min;
  logic [CH-1:0] up_hour;
  logic          busy;

  int cyc     = 0;
  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t q[$];
  int  exp_q[$];

  set_repeat_control #(
    .CH          (CH),
    .HOLD_TICKS  (HOLD),
    .REPEAT_TICKS(REP)
  ) dut (
    .ck        (ck),
    .reset     (reset),
    .tick      (tick),
    .btn_min   (btn_min),
    .btn_hour  (btn_hour),
    .sel       (sel),
    .min_carry (min_carry),
    .hour_carry(hour_carry),
    .up_min    (up_min),
    .up_hour   (up_hour),
    .busy      (busy)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;
  assign tick = ((cyc % 4) == 0);

  always @(negedge ck) begin
    for (int i = 0; i < CH; i++) begin
      if (up_min[i])  q.push_back('{cyc, 0, i});
      if (up_hour[i]) q.push_back('{cyc, 1, i});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: first pulse the cycle after the sampled press; each following pulse
  // comes the cycle after the Nth tick seen strictly after the previous pulse,
  // provided the button is still held in every cycle up to and including that tick.
  function automatic void build_exp(input int s, input int e);
    int p, need, seen;
    bit found;
    exp_q.delete();
    p    = s + 1;
    need = HOLD;
    exp_q.push_back(p);
    while (p <= e) begin
      seen  = 0;
      found = 1'b0;
      for (int t = p + 1; t <= e; t++) begin
        if ((t % 4) == 0) begin
          seen++;
          if (seen == need) begin
            p     = t + 1;
            found = 1'b1;
            break;
          end
        end
      end
      if (!found) break;
      exp_q.push_back(p);
      need = REP;
    end
  endfunction

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic drive_press(input int kind, input int ch, input int len,
                             input bit noise, input bit both,
                             output int s, output int e);
    step();
    q.delete();
    s   = cyc;
    sel = 2'(ch);
    if (kind == 0) btn_min = 1'b1; else btn_hour = 1'b1;
    if (both) begin
      btn_min  = 1'b1;
      btn_hour = 1'b1;
    end
    for (int i = 1; i < len; i++) begin
      step();
      if (noise) begin
        sel = 2'($urandom_range(0, 3));
        if (kind == 0) btn_hour = 1'($urandom_range(0, 1));
        else           btn_min  = 1'($urandom_range(0, 1));
      end
    end
    step();
    btn_min  = 1'b0;
    btn_hour = 1'b0;
    sel      = 2'd0;
    e        = s + len - 1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_min = 1'b0; btn_hour = 1'b0; sel = 2'd0;
    min_carry = 1'b0; hour_carry = 1'b0;
    repeat (3) step();
    nchecks++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    nchecks++;
    if (up_min !== 3'b000) begin nerr++; $display("FAIL reset_up_min: got %b, expected 000", up_min); end
    nchecks++;
    if (up_hour !== 3'b000) begin nerr++; $display("FAIL reset_up_hour: got %b, expected 000", up_hour); end
    min_carry = 1'b1;
    #1;
    nchecks++;
    if (up_min !== 3'b001) begin nerr++; $display("FAIL reset_carry_pass: got %b, expected 001", up_min); end
    min_carry = 1'b0;
    step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_carry_pass();
    min_carry = 1'b1; hour_carry = 1'b1;
    #1;
    nchecks++;
    if (up_min !== 3'b001 || up_hour !== 3'b001) begin
      nerr++; $display("FAIL carry_pass: got min=%b hour=%b, expected 001/001", up_min, up_hour);
    end
    min_carry = 1'b0; hour_carry = 1'b0;
    step();
  endtask

  task automatic test_short_press();
    int s, e;
    drive_press(0, 1, 3, 1'b0, 1'b0, s, e);
    build_exp(s, e);
    nchecks++;
    if (q.size() != exp_q.size()) begin
      nerr++; $display("FAIL short_count: got %0d pulses, expected %0d", q.size(), exp_q.size());
    end
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (q[i].cyc != exp_q[i] || q[i].kind != 0 || q[i].ch != 1) begin
        nerr++; $display("FAIL short_pulse%0d: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=0 ch=1",
                         i, q[i].cyc - s, q[i].kind, q[i].ch, exp_q[i] - s);
      end
    end
    nchecks++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL short_busy_idle: got %b, expected 0", busy); end
  endtask

  task automatic test_long_hold();
    int s, e;
    drive_press(1, 2, 80, 1'b0, 1'b0, s, e);
    build_exp(s, e);
    nchecks++;
    if (q.size() != exp_q.size()) begin
      nerr++; $display("FAIL long_count: got %0d pulses, expected %0d", q.size(), exp_q.size());
    end
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (q[i].cyc != exp_q[i] || q[i].kind != 1 || q[i].ch != 2) begin
        nerr++; $display("FAIL long_pulse%0d: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=1 ch=2",
                         i, q[i].cyc - s, q[i].kind, q[i].ch, exp_q[i] - s);
      end
    end
  endtask

  task automatic test_collision();
    step();
    sel = 2'd0; btn_min = 1'b1;
    step();
    btn_min = 1'b0; min_carry = 1'b1;
    #1;
    nchecks++;
    if (up_min !== 3'b001) begin nerr++; $display("FAIL coll_min_c1: got %b, expected 001", up_min); end
    step();
    min_carry = 1'b0;
    #1;
    nchecks++;
    if (up_min !== 3'b001) begin nerr++; $display("FAIL coll_min_c2: got %b, expected 001", up_min); end
    step();
    nchecks++;
    if (up_min !== 3'b000) begin nerr++; $display("FAIL coll_min_c3: got %b, expected 000", up_min); end
    repeat (3) step();
    // Hour collision with the carry lasting two cycles: pending waits for the gap.
    btn_hour = 1'b1;
    step();
    btn_hour = 1'b0; hour_carry = 1'b1;
    #1;
    nchecks++;
    if (up_hour !== 3'b001) begin nerr++; $display("FAIL coll_hour_c1: got %b, expected 001", up_hour); end
    step();
    nchecks++;
    if (up_hour !== 3'b001) begin nerr++; $display("FAIL coll_hour_c2: got %b, expected 001", up_hour); end
    step();
    hour_carry = 1'b0;
    #1;
    nchecks++;
    if (up_hour !== 3'b001) begin nerr++; $display("FAIL coll_hour_c3: got %b, expected 001", up_hour); end
    step();
    nchecks++;
    if (up_hour !== 3'b000) begin nerr++; $display("FAIL coll_hour_c4: got %b, expected 000", up_hour); end
    repeat (4) step();
  endtask

  task automatic test_priority();
    int s, e;
    drive_press(0, 1, 30, 1'b0, 1'b1, s, e);
    build_exp(s, e);
    nchecks++;
    if (q.size() != exp_q.size()) begin
      nerr++; $display("FAIL prio_count: got %0d pulses, expected %0d", q.size(), exp_q.size());
    end
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (q[i].cyc != exp_q[i] || q[i].kind != 0 || q[i].ch != 1) begin
        nerr++; $display("FAIL prio_pulse%0d: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=0 ch=1",
                         i, q[i].cyc - s, q[i].kind, q[i].ch, exp_q[i] - s);
      end
    end
  endtask

  task automatic test_latch();
    int s;
    step();
    q.delete();
    s = cyc; sel = 2'd1; btn_min = 1'b1;
    repeat (3) step();
    sel = 2'd2;
    repeat (26) step();
    btn_min = 1'b0; sel = 2'd0;
    repeat (8) step();
    build_exp(s, s + 29);
    nchecks++;
    if (q.size() != exp_q.size()) begin
      nerr++; $display("FAIL latch_count: got %0d pulses, expected %0d", q.size(), exp_q.size());
    end
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (q[i].cyc != exp_q[i] || q[i].kind != 0 || q[i].ch != 1) begin
        nerr++; $display("FAIL latch_pulse%0d: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=0 ch=1",
                         i, q[i].cyc - s, q[i].kind, q[i].ch, exp_q[i] - s);
      end
    end
  endtask

  task automatic test_range();
    step();
    q.delete();
    sel = 2'd3; btn_min = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      nchecks++;
      if (busy !== 1'b0) begin nerr++; $display("FAIL range_busy%0d: got %b, expected 0", i, busy); end
    end
    btn_min = 1'b0; sel = 2'd0;
    repeat (3) step();
    nchecks++;
    if (q.size() != 0) begin nerr++; $display("FAIL range_pulses: got %0d pulses, expected 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    int s, e;
    step();
    sel = 2'd1; btn_min = 1'b1;
    repeat (10) step();
    #2;
    reset = 1'b1; min_carry = 1'b1; btn_min = 1'b0;
    #1;
    nchecks++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    nchecks++;
    if (up_min !== 3'b001 || up_hour !== 3'b000) begin
      nerr++; $display("FAIL rstmid_outputs: got min=%b hour=%b, expected 001/000", up_min, up_hour);
    end
    step();
    reset = 1'b0; min_carry = 1'b0; sel = 2'd0;
    q.delete();
    repeat (12) step();
    nchecks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      nerr++; $display("FAIL rstmid_quiet: got %0d pulses busy=%b, expected 0 pulses busy=0", q.size(), busy);
    end
    drive_press(0, 1, 3, 1'b0, 1'b0, s, e);
    nchecks++;
    if (q.size() != 1 || q[0].cyc != s + 1 || q[0].ch != 1 || q[0].kind != 0) begin
      nerr++; $display("FAIL rstmid_new_press: got %0d pulses, expected 1 at +1 on ch1 min", q.size());
    end
  endtask

  task automatic test_random();
    int s, e, kind, ch, len;
    bit noise;
    for (int n = 0; n < 10; n++) begin
      kind  = $urandom_range(0, 1);
      ch    = $urandom_range(0, CH - 1);
      len   = $urandom_range(1, 40);
      noise = 1'($urandom_range(0, 1));
      drive_press(kind, ch, len, noise, 1'b0, s, e);
      build_exp(s, e);
      nchecks++;
      if (q.size() != exp_q.size()) begin
        nerr++; $display("FAIL rand%0d_count: got %0d pulses, expected %0d (kind=%0d ch=%0d len=%0d)",
                         n, q.size(), exp_q.size(), kind, ch, len);
      end
      for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
        nchecks++;
        if (q[i].cyc != exp_q[i] || q[i].kind != kind || q[i].ch != ch) begin
          nerr++; $display("FAIL rand%0d_pulse%0d: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d",
                           n, i, q[i].cyc - s, q[i].kind, q[i].ch, exp_q[i] - s, kind, ch);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_pass();
    test_short_press();
    test_long_hold();
    test_collision();
    test_priority();
    test_latch();
    test_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
